// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader for one routing/IO tile: takes config words over
// valid/ready, serializes them LSB first onto ccff_head and counts CHAIN_LEN bits.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 30,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = 5
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              tail_parity,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned LEFT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [LEFT_W-1:0]   left_q, left_d;
  logic                head_q, head_d;
  logic                shift_en_q, shift_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                parity_q, parity_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                buf_empty;
  logic [CNT_W-1:0]    remain;

  assign buf_empty  = (left_q == '0);
  assign word_ready = (state_q == ST_LOAD) && buf_empty;
  // Bits still owed to the chain; the last word is trimmed to this many.
  assign remain     = CNT_W'(CHAIN_LEN) - cnt_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    left_d     = left_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = aborted_q;
    cnt_d      = cnt_q;
    // Tail is sampled before the chain edge, so this folds in old contents.
    parity_d   = parity_q ^ (shift_en_q & ccff_tail);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          parity_d  = 1'b0;
          aborted_d = 1'b0;
          left_d    = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          left_d    = '0;
        end else if (!buf_empty) begin
          head_d     = buf_q[0];
          shift_en_d = 1'b1;
          buf_d      = buf_q >> 1;
          left_d     = left_q - LEFT_W'(1);
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(CHAIN_LEN)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            left_d  = '0;
          end
        end else if (word_valid) begin
          buf_d  = word_data;
          left_d = (32'(remain) < WORD_W) ? LEFT_W'(remain) : LEFT_W'(WORD_W);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LOAD);
  end

  // State register
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      left_q     <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      parity_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      left_q     <= left_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      parity_q   <= parity_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign tail_parity   = parity_q;
  assign bit_count     = cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 30-bit chain model on the serial port.
module tb_ccff_chain_loader;

  localparam int unsigned CL = 30;
  localparam int unsigned WW = 8;
  localparam int unsigned CW = 5;

  logic          prog_clk   = 1'b0;
  logic          prog_reset = 1'b1;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          word_valid = 1'b0;
  logic [WW-1:0] word_data  = '0;
  logic          word_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          tail_parity;
  logic [CW-1:0] bit_count;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(CW)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .abort         (abort),
    .word_valid    (word_valid),
    .word_data     (word_data),
    .word_ready    (word_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .tail_parity   (tail_parity),
    .bit_count     (bit_count)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model and activity counters
  logic [CL-1:0] chain       = '0;
  logic [CL-1:0] preload_val = '0;
  bit            preload_req = 1'b0;
  int            cyc = 0, n_shift = 0, n_acc = 0, n_viol = 0;
  logic          head_prev = 1'b0;
  bit            bitq[$];

  assign ccff_tail = chain[CL-1];

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (preload_req) chain <= preload_val;
    else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
    if (ccff_shift_en) begin
      n_shift <= n_shift + 1;
      bitq.push_back(ccff_head);
    end
    if (word_valid && word_ready) n_acc <= n_acc + 1;
    if (!ccff_shift_en && (ccff_head != head_prev)) n_viol <= n_viol + 1;
    head_prev <= ccff_head;
  end

  int checks = 0, failures = 0;
  int abort_at = 0, restart_at = 0, reset_at = 0;
  int t0 = 0, t1 = 0, base_shift = 0, base_bits = 0, base_acc = 0;
  logic [WW-1:0] words [4];
  logic [CL-1:0] exp_stream;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One cycle; inputs change at the falling edge, with scheduled mid-load events
  task automatic tick();
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0; prog_reset = 1'b0; preload_req = 1'b0;
    if (busy) begin
      if (abort_at != 0 && int'(bit_count) == abort_at) begin abort = 1'b1; abort_at = 0; end
      if (restart_at != 0 && int'(bit_count) == restart_at) begin start = 1'b1; restart_at = 0; end
      if (reset_at != 0 && int'(bit_count) == reset_at) begin prog_reset = 1'b1; reset_at = 0; end
    end
  endtask

  task automatic run_load(input bit gap);
    int n;
    base_shift = n_shift; base_bits = bitq.size(); base_acc = n_acc;
    word_data = words[0]; word_valid = 1'b1; start = 1'b1;
    tick();
    check("aborted_clr", 32'(aborted), 32'(0));
    for (int w = 0; w < 4; w++) begin
      word_data = words[w]; word_valid = 1'b1;
      n = 0;
      while (!word_ready && busy && n < 100) begin tick(); n++; end
      if (!busy) return;
      if (n >= 100) begin check("ready_timeout", 32'(0), 32'(1)); return; end
      if (w == 0) t0 = cyc;
      tick();
      if (gap && w < 3) begin
        word_valid = 1'b0;
        n = 0;
        while (!word_ready && busy && n < 100) begin tick(); n++; end
        repeat (3) tick();
      end
    end
    word_data = 8'hEE; word_valid = 1'b1;
  endtask

  task automatic finish_load(input string tag, input int lat, input logic [CL-1:0] exp_s,
                             input logic exp_par);
    int n = 0;
    logic [CL-1:0] got_s = '0;
    while (!done && n < 200) begin tick(); n++; end
    check({tag, "_done"}, 32'(done), 32'(1));
    t1 = cyc;
    check({tag, "_lat"}, t1 - t0, lat);
    check({tag, "_rdy_done"}, 32'(word_ready), 32'(0));
    tick();
    check({tag, "_pulse"}, 32'({done, busy, ccff_shift_en}), 32'(0));
    check({tag, "_count"}, 32'(bit_count), CL);
    check({tag, "_shifts"}, n_shift - base_shift, CL);
    for (int i = 0; i < int'(CL); i++)
      if (base_bits + i < bitq.size()) got_s[i] = bitq[base_bits + i];
    check({tag, "_stream"}, 32'(got_s), 32'(exp_s));
    check({tag, "_parity"}, 32'(tail_parity), 32'(exp_par));
    repeat (3) tick();
    check({tag, "_acc"}, n_acc - base_acc, 4);
    word_valid = 1'b0;
  endtask

  initial begin
    int v0, a0;
    prog_reset = 1'b1;
    repeat (2) @(negedge prog_clk);
    check("reset_outs", 32'({ccff_head, ccff_shift_en, busy, done, aborted, tail_parity,
                             word_ready, bit_count}), 32'(0));
    prog_reset = 1'b0;
    preload_val = '0; preload_req = 1'b1;
    tick();

    // Continuous valid; chain was empty
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h15};
    exp_stream = {6'h15, 8'hFF, 8'h3C, 8'hA5};
    run_load(1'b0);
    finish_load("t1", 34, exp_stream, 1'b0);

    // Gaps between words; old chain content has 19 ones
    v0 = n_viol;
    run_load(1'b1);
    finish_load("t2", 43, exp_stream, 1'b1);
    check("t2_head_hold", n_viol - v0, 0);

    // Parity of preloaded content, then of an all-zero chain
    preload_val = 30'h0000_0007; preload_req = 1'b1;
    tick();
    words = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load(1'b0);
    finish_load("t3a", 34, '0, 1'b1);
    run_load(1'b0);
    finish_load("t3b", 34, '0, 1'b0);

    // Abort after 13 bits
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h15};
    abort_at = 13;
    run_load(1'b0);
    check("t4_state", 32'({busy, aborted, ccff_shift_en}), 32'(3'b010));
    check("t4_count", 32'(bit_count), 32'(13));
    repeat (5) tick();
    check("t4_shifts", n_shift - base_shift, 13);
    word_valid = 1'b0;

    // Start during LOAD is ignored; chain holds the 13 aborted bits (7 ones)
    restart_at = 5;
    run_load(1'b0);
    finish_load("t5a", 34, exp_stream, 1'b1);

    // Reset at bit 20
    reset_at = 20;
    run_load(1'b0);
    check("t5b_reset_outs", 32'({ccff_head, ccff_shift_en, busy, done, aborted, tail_parity,
                                 word_ready, bit_count}), 32'(0));
    check("t5b_shifts", n_shift - base_shift, 20);
    word_valid = 1'b0;

    // Valid held in IDLE
    word_valid = 1'b1; word_data = 8'h5A;
    a0 = n_acc;
    repeat (4) begin
      tick();
      check("t6_rdy_idle", 32'(word_ready), 32'(0));
    end
    check("t6_acc", n_acc - a0, 0);
    word_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
